// File: rtl/mul_div_sequencer_pkg.sv
// Shared op codes, ALU selects and FSM state encoding for the RV32M multiply/divide sequencer.
package mul_div_sequencer_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_e;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic rs1_is_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate: y = neg ? -x : x.
module md_sign_fix #(
    parameter int W = 64
) (
    input  logic         neg,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/mul_div_sequencer.sv
// Multi-cycle RV32M sequencer: shift-add multiply and restoring divide driving an external ALU.
module mul_div_sequencer
    import mul_div_sequencer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] alu_r,
    input  logic            alu_cf
);

    // Handshake: a request is taken when in_valid & in_ready at a rising edge,
    // a result is retired when out_valid & out_ready at a rising edge.

    md_state_e         state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_res_q, neg_res_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              out_valid_q, out_valid_d;

    logic              a_neg, b_neg, sub_taken;
    logic [XLEN-1:0]   rem_shift;
    logic [2*XLEN-1:0] fix_src, fix_a_in, fix_a_out;
    logic              fix_a_neg;
    logic [XLEN-1:0]   fix_b_out;

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

    assign a_neg     = rs1_is_signed(op_q) & lo_q[XLEN-1];
    assign b_neg     = rs2_is_signed(op_q) & opnd_q[XLEN-1];
    assign rem_shift = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    // hi_q[MSB] is the bit shifted out of rem_shift; when set the shifted remainder exceeds any divisor.
    assign sub_taken = hi_q[XLEN-1] | alu_cf;

    assign fix_src   = op_is_div(op_q) ? {{XLEN{1'b0}}, (op_is_rem(op_q) ? hi_q : lo_q)}
                                       : {hi_q, lo_q};
    assign fix_a_in  = (state_q == ST_FIX) ? fix_src : {{XLEN{1'b0}}, lo_q};
    assign fix_a_neg = (state_q == ST_FIX) ? neg_res_q : a_neg;

    md_sign_fix #(.W(2*XLEN)) u_fix_a (
        .neg (fix_a_neg),
        .x   (fix_a_in),
        .y   (fix_a_out)
    );

    md_sign_fix #(.W(XLEN)) u_fix_b (
        .neg (b_neg),
        .x   (opnd_q),
        .y   (fix_b_out)
    );

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = ALU_ADD;
        if (state_q == ST_ITER) begin
            alu_b = opnd_q;
            if (op_is_div(op_q)) begin
                alu_a   = rem_shift;
                alu_sel = ALU_SUB;
            end else begin
                alu_a   = hi_q;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opnd_d      = opnd_q;
        cnt_d       = cnt_q;
        neg_res_d   = neg_res_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        if (kill) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            hi_d        = '0;
            lo_d        = '0;
            opnd_d      = '0;
            cnt_d       = '0;
            neg_res_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_d    = funct3;
                        hi_d    = '0;
                        lo_d    = rs1;
                        opnd_d  = rs2;
                        state_d = ST_PREP;
                    end
                end
                ST_PREP: begin
                    cnt_d = '0;
                    if (op_is_div(op_q) && (opnd_q == '0)) begin
                        result_d    = op_is_rem(op_q) ? lo_q : '1;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        lo_d      = fix_a_out[XLEN-1:0];
                        opnd_d    = fix_b_out;
                        neg_res_d = op_is_rem(op_q) ? a_neg : (a_neg ^ b_neg);
                        state_d   = ST_ITER;
                    end
                end
                ST_ITER: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (op_is_div(op_q)) begin
                        // lo_q shifts the dividend out at the top and the quotient in at the bottom.
                        if (sub_taken) begin
                            hi_d = alu_r;
                            lo_d = {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            hi_d = rem_shift;
                            lo_d = {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else if (lo_q[0]) begin
                        hi_d = {alu_cf, alu_r[XLEN-1:1]};
                        lo_d = {alu_r[0], lo_q[XLEN-1:1]};
                    end else begin
                        hi_d = {1'b0, hi_q[XLEN-1:1]};
                        lo_d = {hi_q[0], lo_q[XLEN-1:1]};
                    end
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (op_is_div(op_q) || (op_q == MD_MUL)) begin
                        result_d = fix_a_out[XLEN-1:0];
                    end else begin
                        result_d = fix_a_out[2*XLEN-1:XLEN];
                    end
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            cnt_q       <= '0;
            neg_res_q   <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opnd_q      <= opnd_d;
            cnt_q       <= cnt_d;
            neg_res_q   <= neg_res_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
